image_vector_fetcher: RTL

//  Sequencer between the vector datapath and the image data memory. On Start it sweeps the

---
 rtl/image_vector_fetcher.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/image_vector_fetcher.sv
// Sweeps the image in LANES-pixel chunks, captures memory read data into a registered
// output vector and streams it downstream over valid/ready with row/column tags.
module image_vector_fetcher #(
  parameter int unsigned IMAGE_WIDTH  = 96,
  parameter int unsigned IMAGE_HEIGHT = 96,
  parameter int unsigned PIX_SIZE     = 8,
  parameter int unsigned LANES        = 8,
  parameter int unsigned VEC_LANES    = 16,
  parameter int unsigned LANE_W       = 16
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              Start,
  input  logic                              Abort,
  output logic [15:0]                       Addr,
  input  logic [VEC_LANES-1:0][LANE_W-1:0]  RD,
  output logic [VEC_LANES-1:0][LANE_W-1:0]  VecOut,
  output logic                              VecValid,
  input  logic                              VecReady,
  output logic [15:0]                       RowTag,
  output logic [15:0]                       ColTag,
  output logic                              Busy,
  output logic                              Done
);

  localparam int unsigned NCHUNK   = IMAGE_WIDTH * IMAGE_HEIGHT / LANES;
  localparam int unsigned CPR      = IMAGE_WIDTH / LANES;
  localparam logic [15:0] LAST_PTR = 16'(NCHUNK - 1);
  localparam logic [15:0] LAST_COL = 16'(CPR - 1);
  localparam logic [15:0] LANES16  = 16'(LANES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                           state_q;
  logic [15:0]                      ptr_q;
  logic [15:0]                      row_q;
  logic [15:0]                      col_q;
  logic [VEC_LANES-1:0][LANE_W-1:0] vec_q;
  logic [VEC_LANES-1:0][LANE_W-1:0] vec_d;
  logic                             valid_q;
  logic [15:0]                      row_tag_q;
  logic [15:0]                      col_tag_q;
  logic                             busy_q;
  logic                             done_q;
  logic                             load_c;
  logic                             unused_rd;

  // Only the low PIX_SIZE bits of the first LANES lanes carry pixel data.
  assign unused_rd = ^RD;

  // Zero-extend the valid pixel bits; lanes beyond LANES are forced to zero.
  always_comb begin
    vec_d = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      vec_d[i] = LANE_W'(RD[i][PIX_SIZE-1:0]);
    end
  end

  // A new chunk may enter the output register when it is empty or being drained this cycle.
  assign load_c = (state_q == S_RUN) && (!valid_q || VecReady);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      vec_q     <= '0;
      valid_q   <= 1'b0;
      row_tag_q <= '0;
      col_tag_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            ptr_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end

        S_RUN: begin
          if (Abort) begin
            valid_q <= 1'b0;
            ptr_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (load_c) begin
            vec_q     <= vec_d;
            row_tag_q <= row_q;
            col_tag_q <= col_q;
            valid_q   <= 1'b1;
            // ptr parks on the last chunk so Addr never runs past the image.
            if (ptr_q == LAST_PTR) begin
              state_q <= S_DRAIN;
            end else begin
              ptr_q <= ptr_q + 16'd1;
              if (col_q == LAST_COL) begin
                col_q <= '0;
                row_q <= row_q + 16'd1;
              end else begin
                col_q <= col_q + 16'd1;
              end
            end
          end
        end

        S_DRAIN: begin
          if (Abort) begin
            valid_q <= 1'b0;
            ptr_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (VecReady) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            ptr_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Addr     = ptr_q * LANES16;
  assign VecOut   = vec_q;
  assign VecValid = valid_q;
  assign RowTag   = row_tag_q;
  assign ColTag   = col_tag_q;
  assign Busy     = busy_q;
  assign Done     = done_q;

endmodule
